// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default frame/divider constants,
// used by the master RTL and by the responder model in the bench.
package spi_pkg;

  localparam int SPI_MSB_DEF     = 16;
  localparam int SPI_CLK_DIV_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// Frame request/response and SPI pin bundle for spi_master.
// The master modport is the controller side, slave is the requester/responder side.
interface spi_master_if
  import spi_pkg::*;
#(
  parameter int MSB = SPI_MSB_DEF
);

  logic           start;
  logic [MSB-1:0] tx_data;
  logic [MSB-1:0] rx_data;
  logic           busy;
  logic           done;
  logic           sclk;
  logic           cs;
  logic           mosi;
  logic           miso;

  modport master (
    input  start,
    input  tx_data,
    input  miso,
    output rx_data,
    output busy,
    output done,
    output sclk,
    output cs,
    output mosi
  );

  modport slave (
    output start,
    output tx_data,
    output miso,
    input  rx_data,
    input  busy,
    input  done,
    input  sclk,
    input  cs,
    input  mosi
  );

endinterface

// File: rtl/spi_tick.sv
// Half-period divider: tick is high in the last cycle of each CLK_DIV-cycle phase.
// Held at zero while restart is high so the first phase after IDLE is full length.
module spi_tick
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = (cnt_reg == CNT_W'(CLK_DIV - 1));

  // Wrapping on tick lines the counter up with every subsequent state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (restart || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-1 style frame master: MSB-first, mosi launched on rising SCLK, miso captured late in LOW.
// Define SPI_MASTER_READBACK_EN to build the miso receive path; otherwise rx_data reads as 0.
module spi_master
  import spi_pkg::*;
#(
  parameter int MSB     = SPI_MSB_DEF,
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_if.master      bus
);

  localparam int BIT_W = $clog2(MSB + 1);

  spi_state_e       state_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [MSB-2:0]   tx_sh_reg;
  logic             cs_reg;
  logic             sclk_reg;
  logic             mosi_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             tick;

  spi_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (state_reg == IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      tx_sh_reg   <= '0;
      cs_reg      <= 1'b1;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg   <= SETUP;
            bit_cnt_reg <= '0;
            tx_sh_reg   <= bus.tx_data[MSB-2:0];
            mosi_reg    <= bus.tx_data[MSB-1];
            cs_reg      <= 1'b0;
            busy_reg    <= 1'b1;
          end
        end
        SETUP: begin
          if (tick) begin
            state_reg <= HIGH;
            sclk_reg  <= 1'b1;
          end
        end
        HIGH: begin
          if (tick) begin
            state_reg   <= LOW;
            sclk_reg    <= 1'b0;
            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
          end
        end
        LOW: begin
          if (tick) begin
            if (bit_cnt_reg == BIT_W'(MSB)) begin
              state_reg <= HOLD;
            end else begin
              // The first bit was already launched at accept; later bits launch here.
              state_reg <= HIGH;
              sclk_reg  <= 1'b1;
              mosi_reg  <= tx_sh_reg[MSB-2];
              tx_sh_reg <= {tx_sh_reg[MSB-3:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_reg <= GAP;
            cs_reg    <= 1'b1;
            mosi_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        GAP: begin
          if (tick) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cs   = cs_reg;
  assign bus.sclk = sclk_reg;
  assign bus.mosi = mosi_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

`ifdef SPI_MASTER_READBACK_EN
  logic [MSB-1:0] rx_sh_reg;
  logic [MSB-1:0] rx_data_reg;

  // Capture at the end of LOW, well after the responder moved miso on the falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh_reg   <= '0;
      rx_data_reg <= '0;
    end else begin
      if (state_reg == LOW && tick) begin
        rx_sh_reg <= {rx_sh_reg[MSB-2:0], bus.miso};
      end
      if (state_reg == HOLD && tick) begin
        rx_data_reg <= rx_sh_reg;
      end
    end
  end

  assign bus.rx_data = rx_data_reg;
`else
  logic unused_miso;
  assign unused_miso = bus.miso;
  assign bus.rx_data = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a 16-bit/CLK_DIV=4 instance and an 8-bit/CLK_DIV=1 instance,
// each with a falling-edge responder model and a scoreboard of expected frames.
module tb_spi_master;
  import spi_pkg::*;

  typedef struct {
    logic [15:0] tx;
    logic [15:0] rx;
    int          cs_len;
    int          nbits;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_if #(.MSB(SPI_MSB_DEF)) bus16 ();
  spi_master_if #(.MSB(8))           bus8  ();

  spi_master #(.MSB(SPI_MSB_DEF), .CLK_DIV(SPI_CLK_DIV_DEF)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  spi_master #(.MSB(8), .CLK_DIV(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int checks = 0;
  int errors = 0;

  exp_t q16[$];
  exp_t q8[$];
  exp_t e16, e8;

  logic [15:0] resp16 = 16'h0;
  logic [7:0]  resp8  = 8'h0;
  logic [15:0] word16, word8;
  int fall16, fall8, cslow16, cslow8, cshigh16, done16, done8;
  logic prev_sclk16, prev_sclk8, prev_cs16;
  logic gap_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rx(input logic [15:0] resp);
`ifdef SPI_MASTER_READBACK_EN
    return resp;
`else
    return 16'h0;
`endif
  endfunction

  // 16-bit monitor and responder: miso moves on each SCLK falling edge, MSB first.
  initial begin
    done16 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fall16 = 0; word16 = '0; cslow16 = 0; cshigh16 = 0;
        prev_sclk16 = 1'b0; prev_cs16 = 1'b1; bus16.miso = 1'b0;
      end else begin
        if (prev_sclk16 && !bus16.sclk) begin
          if (fall16 < 16) bus16.miso = resp16[15-fall16];
          word16 = {word16[14:0], bus16.mosi};
          fall16++;
        end
        if (!bus16.cs) cslow16++;
        else cshigh16++;
        if (prev_cs16 && !bus16.cs) begin
          if (gap_chk) check("gap16_cs_high", 32'(cshigh16 >= 4), 32'd1);
          cshigh16 = 0;
        end
        if (bus16.done) begin
          done16++;
          check("done16_expected", 32'(q16.size() > 0), 32'd1);
          if (q16.size() > 0) begin
            e16 = q16.pop_front();
            check("mosi16_bits", 32'(word16), 32'(e16.tx));
            check("rx16_data", 32'(bus16.rx_data), 32'(e16.rx));
            check("falls16", 32'(fall16), 32'(e16.nbits));
            check("cs16_low_len", 32'(cslow16), 32'(e16.cs_len));
            check("idle16_pins", {30'd0, bus16.sclk, bus16.mosi}, 32'd0);
          end
          fall16 = 0; word16 = '0; cslow16 = 0;
        end
        prev_sclk16 = bus16.sclk;
        prev_cs16   = bus16.cs;
      end
    end
  end

  // 8-bit monitor and responder.
  initial begin
    done8 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fall8 = 0; word8 = '0; cslow8 = 0; prev_sclk8 = 1'b0; bus8.miso = 1'b0;
      end else begin
        if (prev_sclk8 && !bus8.sclk) begin
          if (fall8 < 8) bus8.miso = resp8[7-fall8];
          word8 = {word8[14:0], bus8.mosi};
          fall8++;
        end
        if (!bus8.cs) cslow8++;
        if (bus8.done) begin
          done8++;
          check("done8_expected", 32'(q8.size() > 0), 32'd1);
          if (q8.size() > 0) begin
            e8 = q8.pop_front();
            check("mosi8_bits", 32'(word8), 32'(e8.tx));
            check("rx8_data", 32'(bus8.rx_data), 32'(e8.rx));
            check("falls8", 32'(fall8), 32'(e8.nbits));
            check("cs8_low_len", 32'(cslow8), 32'(e8.cs_len));
          end
          fall8 = 0; word8 = '0; cslow8 = 0;
        end
        prev_sclk8 = bus8.sclk;
      end
    end
  end

  task automatic wait_done16(input int target, input int budget);
    for (int i = 0; i < budget && done16 < target; i++) @(posedge clk);
    check("wait16_done", 32'(done16 >= target), 32'd1);
    #1;
  endtask

  task automatic wait_done8(input int target, input int budget);
    for (int i = 0; i < budget && done8 < target; i++) @(posedge clk);
    check("wait8_done", 32'(done8 >= target), 32'd1);
    #1;
  endtask

  task automatic push16(input logic [15:0] tx, input logic [15:0] resp);
    exp_t e;
    e.tx = tx; e.rx = exp_rx(resp); e.cs_len = 136; e.nbits = 16;
    q16.push_back(e);
  endtask

  initial begin
    int d;
    exp_t e;
    bus16.start = 1'b0; bus16.tx_data = '0;
    bus8.start  = 1'b0; bus8.tx_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst16_cs", 32'(bus16.cs), 32'd1);
    check("rst16_sclk_mosi", {30'd0, bus16.sclk, bus16.mosi}, 32'd0);
    check("rst16_busy_done", {30'd0, bus16.busy, bus16.done}, 32'd0);
    check("rst16_rx", 32'(bus16.rx_data), 32'd0);
    check("rst8_cs_busy", {30'd0, bus8.cs, bus8.busy}, 32'd2);

    // First frame accepted on the first edge after reset release
    @(negedge clk);
    rst = 1'b0;
    resp16 = 16'h0A00;
    bus16.tx_data = 16'h0705;
    bus16.start = 1'b1;
    push16(16'h0705, 16'h0A00);
    @(posedge clk);
    #1;
    check("accept16_cs", 32'(bus16.cs), 32'd0);
    check("accept16_busy", 32'(bus16.busy), 32'd1);
    bus16.start = 1'b0;
    wait_done16(1, 400);
    repeat (10) @(posedge clk);
    #1;
    check("frame1_done_count", 32'(done16), 32'd1);
    check("frame1_idle_busy", 32'(bus16.busy), 32'd0);

    // Second start 10 cycles into the frame is ignored
    resp16 = 16'h5A3C;
    bus16.tx_data = 16'h1234;
    bus16.start = 1'b1;
    push16(16'h1234, 16'h5A3C);
    @(posedge clk); #1;
    bus16.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus16.tx_data = 16'hFFFF;
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    wait_done16(2, 400);
    repeat (20) @(posedge clk);
    #1;
    check("ignore_done_count", 32'(done16), 32'd2);
    check("ignore_busy", 32'(bus16.busy), 32'd0);
    check("ignore_queue", 32'(q16.size()), 32'd0);

    // Reset after the 5th falling edge aborts the frame
    d = done16;
    resp16 = 16'h3C3C;
    bus16.tx_data = 16'hBEEF;
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    for (int i = 0; i < 200 && fall16 < 5; i++) @(posedge clk);
    check("abort_reach_fall5", 32'(fall16), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("abort_cs", 32'(bus16.cs), 32'd1);
    check("abort_sclk", 32'(bus16.sclk), 32'd0);
    check("abort_busy", 32'(bus16.busy), 32'd0);
    check("abort_done_rx", {15'd0, bus16.done, bus16.rx_data}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_no_done", 32'(done16), 32'(d));
    resp16 = 16'h00FF;
    bus16.tx_data = 16'hC3A5;
    bus16.start = 1'b1;
    push16(16'hC3A5, 16'h00FF);
    @(posedge clk); #1;
    bus16.start = 1'b0;
    wait_done16(d + 1, 400);

    // Start held high: back-to-back frames with a cs-high gap
    repeat (10) @(posedge clk);
    #1;
    d = done16;
    gap_chk = 1'b1;
    resp16 = 16'h1111;
    bus16.tx_data = 16'h8001;
    bus16.start = 1'b1;
    push16(16'h8001, 16'h1111);
    wait_done16(d + 1, 400);
    resp16 = 16'h2222;
    bus16.tx_data = 16'h7FFE;
    push16(16'h7FFE, 16'h2222);
    wait_done16(d + 2, 400);
    resp16 = 16'h4444;
    bus16.tx_data = 16'h0F0F;
    push16(16'h0F0F, 16'h4444);
    wait_done16(d + 3, 400);
    bus16.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    gap_chk = 1'b0;
    check("b2b_done_count", 32'(done16), 32'(d + 3));
    check("b2b_queue", 32'(q16.size()), 32'd0);

    // 8-bit frame with CLK_DIV=1
    foreach (resp8[i]) resp8[i] = (i == 2 || i == 3 || i == 4 || i == 5);
    bus8.tx_data = 8'hA5;
    bus8.start = 1'b1;
    e.tx = 16'h00A5; e.rx = exp_rx({8'h00, resp8}); e.cs_len = 18; e.nbits = 8;
    q8.push_back(e);
    @(posedge clk); #1;
    check("accept8_cs", 32'(bus8.cs), 32'd0);
    check("accept8_mosi", 32'(bus8.mosi), 32'd1);
    bus8.start = 1'b0;
    wait_done8(1, 100);
    repeat (5) @(posedge clk);
    #1;
    resp8 = 8'hC3;
    bus8.tx_data = 8'h5A;
    bus8.start = 1'b1;
    e.tx = 16'h005A; e.rx = exp_rx(16'h00C3); e.cs_len = 18; e.nbits = 8;
    q8.push_back(e);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait_done8(2, 100);
    repeat (5) @(posedge clk);
    #1;
    check("frame8_done_count", 32'(done8), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
